buff_wr_sequencer: RTL and testbench
====================================

# buff_wr_sequencer

Write-side sequencer for the 8-entry 64-bit pulse buffer. Accepts 64-bit words from an upstream valid/ready stream, assigns them sequential buffer addresses starting at 0 within a frame, and drives the buffer write port (`wr_en`/`wr_addr`/`wr_data`). It tracks how many written words the read-side controller has consumed, using that controller's per-word valid pulse as `rd_ack`. It holds off upstream until the whole frame has drained before starting the next one.

## Interface
- `DATA_W`, 64, data word width
- `DEPTH`, 8, buffer entries and maximum words per frame
- `ADDR_W`, 3, buffer address width (log2 DEPTH)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  block enable; low = synchronous clear to IDLE
- `s_data`  in  DATA_W  upstream word
- `s_valid`  in  1  upstream word valid
- `s_last`  in  1  last word of frame, qualified by `s_valid`
- `s_ready`  out  1  sequencer can accept a word
- `wr_en`  out  1  buffer write strobe, one cycle per word
- `wr_addr`  out  ADDR_W  buffer write address
- `wr_data`  out  DATA_W  buffer write data
- `rd_ack`  in  1  one-cycle pulse per word consumed by read side
- `fill_level`  out  ADDR_W+1  words written and not yet acknowledged, 0..DEPTH
- `frame_done`  out  1  one-cycle pulse when the frame has fully drained
- `frame_len`  out  ADDR_W+1  word count of the last completed frame, 1..DEPTH
- `ack_err`  out  1  sticky; `rd_ack` received with no outstanding word

## Operation
- Accept occurs when `s_valid && s_ready`.
- `s_ready` is combinational: `en && (state==IDLE || state==FILL)`.
- States:
  - IDLE: `wr_ptr`=0, `wr_cnt`=0.
    - Accept with `s_last`=0 -> FILL.
    - Accept with `s_last`=1 -> DRAIN.
  - FILL: each accept increments `wr_ptr` and `wr_cnt`.
    - Accept with `s_last`=1 -> DRAIN.
    - Accept making `wr_cnt`==DEPTH -> DRAIN. The frame is truncated at DEPTH words; the next upstream word begins a new frame.
  - DRAIN: no accepts.
    - -> DONE when `fill_level`==0 and no write is pending.
  - DONE: one cycle.
    - `frame_done`=1 and `frame_len`<=`wr_cnt`.
    - -> IDLE; `wr_ptr` and `wr_cnt` cleared.
- Each accepted word is written at address `wr_ptr`. Addresses within a frame are strictly sequential 0,1,...,`wr_cnt`-1 and never wrap.
- `fill_level` update each cycle:
  - +1 on `wr_en`.
  - -1 on `rd_ack` when `fill_level`>0, or when a write occurs in the same cycle.
  - Simultaneous `wr_en` and `rd_ack` leave it unchanged.
- `rd_ack` with `fill_level`==0 and no simultaneous `wr_en`: set `ack_err`; `fill_level` stays 0.
- `en` low: state -> IDLE; `wr_ptr`, `wr_cnt`, `fill_level`, `wr_en`, `frame_done` and `ack_err` cleared. `frame_len` holds its value.
- `rst` mid-frame: the frame is abandoned and all state returns to reset values. No `frame_done` is issued.

## Timing
- Reset values:
  - `s_ready`=0 while `rst` is asserted.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `fill_level`=0, `frame_done`=0, `frame_len`=0, `ack_err`=0.
  - state=IDLE.
- Write latency: registered outputs. A word accepted at edge N appears on `wr_en`/`wr_addr`/`wr_data` during cycle N+1, for exactly one cycle.
- `fill_level` is registered and increments in the cycle after the `wr_en` cycle.
- Back-to-back accepts give back-to-back writes: throughput is one word per cycle in IDLE/FILL.
- `s_ready` drops the cycle after the accepting edge of the final word. No accept is possible in DRAIN or DONE.
- `frame_done` is asserted in the cycle after `fill_level` first reads 0 in DRAIN with no pending write. IDLE follows one cycle later, so `s_ready` rises 1 cycle after `frame_done`.
- `rd_ack` is sampled every cycle in every state; there is no minimum spacing.

## Test plan
- Three-word frame, continuous valid, `s_last` on word 3 -> `wr_addr` 0,1,2 on consecutive cycles; `s_ready` low after word 3; `fill_level` peaks at 3. Three `rd_ack` pulses -> `frame_done` pulse, `frame_len`=3, `s_ready` back high.
- Ten words with no `s_last` -> first frame writes addresses 0..7 and deasserts `s_ready`. After 8 acks: `frame_done`, `frame_len`=8. Words 9-10 then start a new frame at addresses 0,1.
- Single word with `s_last` in IDLE -> direct to DRAIN; write at address 0. `rd_ack` in the same cycle as `wr_en` -> `fill_level` stays 0; `frame_done` follows with `frame_len`=1.
- `rd_ack` while in IDLE with `fill_level`=0 -> `ack_err`=1 and stays set through later frames. Then `en` pulsed low -> `ack_err`=0.
- Assert `rst` during FILL after 5 writes -> all outputs return to reset values immediately, no `frame_done`. Next frame starts at address 0.
- `s_valid` gapped (valid every other cycle) across a 4-word frame -> writes at 0..3 each one cycle after its accept; `wr_en` never asserted without a preceding accept.

Source files
------------

// File: rtl/buff_wr_sequencer_if.sv
// Upstream word stream into the pulse-buffer write sequencer.
// master drives words, slave returns ready.
interface buff_wr_sequencer_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/buff_wr_sequencer.sv
// Write-side sequencer for the 8-entry pulse buffer: sequential
// addressing per frame, fill tracking from read acks, frame drain hold-off.
module buff_wr_sequencer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  buff_wr_sequencer_if.slave s,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_ack,
  output logic [ADDR_W:0]   fill_level,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_len,
  output logic              ack_err
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     cnt_inc;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;
  logic [ADDR_W:0]     len_q;
  logic                err_q;
  logic                accept;
  logic                ack_ok;
  logic                ack_bad;
  logic                to_done;

  assign s.s_ready = en && !rst &&
                     (state_q == IDLE || state_q == FILL);
  assign accept    = s.s_valid && s.s_ready;
  assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

  // an ack is legal if a word is outstanding or lands this cycle
  assign ack_ok  = rd_ack && (fill_q != '0 || wr_en_q);
  assign ack_bad = rd_ack && fill_q == '0 && !wr_en_q;
  assign to_done = (state_q == DRAIN) && (state_d == DONE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_inc;
          if (s.s_last || cnt_inc == DEPTH_C) state_d = DRAIN;
          else                                state_d = FILL;
        end
      end
      DRAIN: begin
        if (fill_q == '0 && !wr_en_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    unique case ({wr_en_q, ack_ok})
      2'b10:   fill_d = fill_q + (ADDR_W+1)'(1);
      2'b01:   fill_d = fill_q - (ADDR_W+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      wr_en_q <= accept;
      if (accept) begin
        addr_q <= ptr_q;
        data_q <= s.s_data;
      end
      done_q <= to_done;
      if (to_done) len_q <= cnt_q;
      err_q <= err_q | ack_bad;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign fill_level = fill_q;
  assign frame_done = done_q;
  assign frame_len  = len_q;
  assign ack_err    = err_q;

endmodule

// File: tb/tb_buff_wr_sequencer.sv
// Directed bench for buff_wr_sequencer: table-driven frame plus
// hand sequences for truncation, single word, ack errors, reset, gaps.
module tb_buff_wr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rd_ack;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  fill_level;
  logic        frame_done;
  logic [3:0]  frame_len;
  logic        ack_err;

  int checks = 0;
  int errors = 0;

  buff_wr_sequencer_if #(.DATA_W(64)) s_if ();

  buff_wr_sequencer #(
    .DATA_W(64),
    .DEPTH (8),
    .ADDR_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s         (s_if),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_ack    (rd_ack),
    .fill_level(fill_level),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        l;
    logic [63:0] d;
    logic        ack;
    logic        rdy;
    logic        wr;
    logic [2:0]  addr;
    logic [63:0] data;
    logic [3:0]  fill;
    logic        done;
    logic [3:0]  len;
    logic        err;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle's inputs after the falling edge, settle, then check
  task automatic cyc(input logic v, input logic l,
                     input logic [63:0] d, input logic a);
    @(negedge clk);
    s_if.s_valid = v;
    s_if.s_last  = l;
    s_if.s_data  = d;
    rd_ack       = a;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{1,0,64'hA0,0, 1,0,3'd0,64'h0, 4'd0,0,4'd0,0};
    tv[1] = '{1,0,64'hA1,0, 1,1,3'd0,64'hA0,4'd0,0,4'd0,0};
    tv[2] = '{1,1,64'hA2,0, 1,1,3'd1,64'hA1,4'd1,0,4'd0,0};
    tv[3] = '{0,0,64'h0,0,  0,1,3'd2,64'hA2,4'd2,0,4'd0,0};
    tv[4] = '{0,0,64'h0,1,  0,0,3'd0,64'h0, 4'd3,0,4'd0,0};
    tv[5] = '{0,0,64'h0,1,  0,0,3'd0,64'h0, 4'd2,0,4'd0,0};
    tv[6] = '{0,0,64'h0,1,  0,0,3'd0,64'h0, 4'd1,0,4'd0,0};
    tv[7] = '{0,0,64'h0,0,  0,0,3'd0,64'h0, 4'd0,0,4'd0,0};
    tv[8] = '{0,0,64'h0,0,  0,0,3'd0,64'h0, 4'd0,1,4'd3,0};
    tv[9] = '{0,0,64'h0,0,  1,0,3'd0,64'h0, 4'd0,0,4'd3,0};

    rst = 1'b1;
    en = 1'b1;
    rd_ack = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_last = 1'b0;
    s_if.s_data = 64'h0;
    #12;
    chk("rst ready", s_if.s_ready, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst addr", wr_addr, 0);
    chk("rst data", wr_data, 0);
    chk("rst fill", fill_level, 0);
    chk("rst done", frame_done, 0);
    chk("rst len", frame_len, 0);
    chk("rst err", ack_err, 0);
    @(negedge clk);
    s_if.s_valid = 1'b0;
    rst = 1'b0;

    // three-word frame
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].v, tv[i].l, tv[i].d, tv[i].ack);
      chk($sformatf("t3w[%0d] ready", i), s_if.s_ready, tv[i].rdy);
      chk($sformatf("t3w[%0d] wr_en", i), wr_en, tv[i].wr);
      if (tv[i].wr) begin
        chk($sformatf("t3w[%0d] addr", i), wr_addr, tv[i].addr);
        chk($sformatf("t3w[%0d] data", i), wr_data, tv[i].data);
      end
      chk($sformatf("t3w[%0d] fill", i), fill_level, tv[i].fill);
      chk($sformatf("t3w[%0d] done", i), frame_done, tv[i].done);
      chk($sformatf("t3w[%0d] len", i), frame_len, tv[i].len);
      chk($sformatf("t3w[%0d] err", i), ack_err, tv[i].err);
    end

    // stray ack in IDLE
    cyc(0, 0, 0, 1);
    chk("err pre", ack_err, 0);
    cyc(0, 0, 0, 0);
    chk("err set", ack_err, 1);
    chk("err fill", fill_level, 0);

    // single word with last; ack coincident with write
    cyc(1, 1, 64'hD5, 0);
    chk("one ready", s_if.s_ready, 1);
    cyc(0, 0, 0, 1);
    chk("one wr_en", wr_en, 1);
    chk("one addr", wr_addr, 0);
    chk("one data", wr_data, 64'hD5);
    chk("one ready lo", s_if.s_ready, 0);
    cyc(0, 0, 0, 0);
    chk("one fill", fill_level, 0);
    chk("one wr_en off", wr_en, 0);
    chk("one err sticky", ack_err, 1);
    chk("one done early", frame_done, 0);
    cyc(0, 0, 0, 0);
    chk("one done", frame_done, 1);
    chk("one len", frame_len, 1);
    cyc(0, 0, 0, 0);
    chk("one ready back", s_if.s_ready, 1);
    chk("one err still", ack_err, 1);

    // en pulse clears the sticky error, keeps frame_len
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("en lo ready", s_if.s_ready, 0);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("en err clr", ack_err, 0);
    chk("en len hold", frame_len, 1);
    chk("en ready", s_if.s_ready, 1);

    // ten words, no last: truncated at 8
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 64'd200 + 64'(i), 0);
      chk($sformatf("t10[%0d] ready", i), s_if.s_ready, 1);
      chk($sformatf("t10[%0d] fill", i), fill_level,
          (i == 0) ? 0 : i - 1);
      if (i >= 1) begin
        chk($sformatf("t10[%0d] wr_en", i), wr_en, 1);
        chk($sformatf("t10[%0d] addr", i), wr_addr, i - 1);
        chk($sformatf("t10[%0d] data", i), wr_data,
            64'd200 + 64'(i - 1));
      end
    end
    cyc(1, 0, 64'd208, 0);
    chk("t10 ready lo", s_if.s_ready, 0);
    chk("t10 last addr", wr_addr, 7);
    chk("t10 last data", wr_data, 64'd207);
    chk("t10 fill7", fill_level, 7);
    for (int j = 0; j < 8; j++) begin
      cyc(1, 0, 64'd208, 1);
      chk($sformatf("t10 ack[%0d] fill", j), fill_level, 8 - j);
      chk($sformatf("t10 ack[%0d] wr_en", j), wr_en, 0);
      chk($sformatf("t10 ack[%0d] ready", j), s_if.s_ready, 0);
    end
    cyc(1, 0, 64'd208, 0);
    chk("t10 fill0", fill_level, 0);
    chk("t10 done early", frame_done, 0);
    cyc(1, 0, 64'd208, 0);
    chk("t10 done", frame_done, 1);
    chk("t10 len", frame_len, 8);
    chk("t10 ready done", s_if.s_ready, 0);
    cyc(1, 0, 64'd208, 0);
    chk("t10 ready new", s_if.s_ready, 1);
    cyc(1, 0, 64'd209, 0);
    chk("t10 w9 wr_en", wr_en, 1);
    chk("t10 w9 addr", wr_addr, 0);
    chk("t10 w9 data", wr_data, 64'd208);
    cyc(0, 0, 0, 0);
    chk("t10 w10 wr_en", wr_en, 1);
    chk("t10 w10 addr", wr_addr, 1);
    chk("t10 w10 data", wr_data, 64'd209);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("en2 fill", fill_level, 0);
    chk("en2 wr_en", wr_en, 0);
    chk("en2 ready", s_if.s_ready, 1);

    // reset during FILL after five writes
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 64'd300 + 64'(i), 0);
      chk($sformatf("rf[%0d] ready", i), s_if.s_ready, 1);
    end
    cyc(0, 0, 0, 0);
    chk("rf addr4", wr_addr, 4);
    chk("rf fill4", fill_level, 4);
    #1;
    rst = 1'b1;
    #1;
    chk("rf ready", s_if.s_ready, 0);
    chk("rf wr_en", wr_en, 0);
    chk("rf addr", wr_addr, 0);
    chk("rf data", wr_data, 0);
    chk("rf fill", fill_level, 0);
    chk("rf done", frame_done, 0);
    chk("rf len", frame_len, 0);
    chk("rf err", ack_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("rf post[%0d] done", i), frame_done, 0);
      chk($sformatf("rf post[%0d] ready", i), s_if.s_ready, 1);
    end

    // gapped valid, four-word frame
    for (int k = 0; k < 4; k++) begin
      cyc(1, k == 3, 64'd400 + 64'(k), 0);
      chk($sformatf("gap[%0d] ready", k), s_if.s_ready, 1);
      chk($sformatf("gap[%0d] wr_en idle", k), wr_en, 0);
      chk($sformatf("gap[%0d] fill", k), fill_level, k);
      cyc(0, 0, 0, 0);
      chk($sformatf("gap[%0d] wr_en", k), wr_en, 1);
      chk($sformatf("gap[%0d] addr", k), wr_addr, k);
      chk($sformatf("gap[%0d] data", k), wr_data, 64'd400 + 64'(k));
      chk($sformatf("gap[%0d] ready odd", k), s_if.s_ready,
          (k < 3) ? 1 : 0);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 1);
      chk($sformatf("gap ack[%0d] fill", j), fill_level, 4 - j);
      chk($sformatf("gap ack[%0d] wr_en", j), wr_en, 0);
    end
    cyc(0, 0, 0, 0);
    chk("gap fill0", fill_level, 0);
    cyc(0, 0, 0, 0);
    chk("gap done", frame_done, 1);
    chk("gap len", frame_len, 4);
    cyc(0, 0, 0, 0);
    chk("gap ready", s_if.s_ready, 1);
    chk("gap done off", frame_done, 0);
    chk("gap err", ack_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
